imm_alu_core: RTL and testbench

- Parametrised successor to the single-path immediate datapath in the NPC CPU.
- Multi-cycle core that accepts one RV instruction per valid/ready handshake and decodes it.
- Reads rs1 from an internal register file and executes the full OP-IMM / OP-IMM-32 / LUI set.
- Writes rd back and flags ebreak/illegal instructions through sticky halt outputs.

---
 rtl/imm_alu_core.sv | 175 +++++++++++++++++
 tb/tb_imm_alu_core.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_alu_core.sv
// Multi-cycle immediate-ALU core: accepts one RV instruction per handshake, executes
// OP-IMM / OP-IMM-32 / LUI against an internal register file, halts on ebreak/illegal.
module imm_alu_core #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32,
  localparam int unsigned RW   = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_inst_valid,
  output logic            io_inst_ready,
  input  logic [31:0]     io_inst,
  output logic            io_out_valid,
  output logic [XLEN-1:0] io_out,
  output logic [RW-1:0]   io_out_rd,
  output logic            io_halt,
  output logic            io_illegal,
  input  logic [RW-1:0]   io_dbg_raddr,
  output logic [XLEN-1:0] io_dbg_rdata
);

  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, EXEC, WB, HALT} state_e;

  state_e          state_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] out_q;
  logic [RW-1:0]   rd_q;
  logic            halt_q;
  logic            illegal_q;
  logic [XLEN-1:0] rf_q [NREGS];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1_idx;
  logic [4:0]      rd_idx;
  logic            rs1_oob;
  logic            rd_oob;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] rs1_val;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] sra_x;
  logic [31:0]     sra_w;
  logic [31:0]     w_res;
  logic            sll_ok;
  logic            sr_ok;
  logic            ebreak_d;
  logic            legal_d;
  logic [XLEN-1:0] result_d;

  always_comb begin
    opcode   = inst_q[6:0];
    funct3   = inst_q[14:12];
    rs1_idx  = inst_q[19:15];
    rd_idx   = inst_q[11:7];
    rs1_oob  = 32'(rs1_idx) >= NREGS;
    rd_oob   = 32'(rd_idx) >= NREGS;
    imm_i    = XLEN'($signed(inst_q[31:20]));
    imm_u    = XLEN'($signed({inst_q[31:12], 12'b0}));
    rs1_val  = (rs1_idx == 5'd0 || rs1_oob) ? '0 : rf_q[rs1_idx[RW-1:0]];
    shamt    = inst_q[20 +: SW];
    sra_x    = $signed(rs1_val) >>> shamt;
    sra_w    = $signed(rs1_val[31:0]) >>> inst_q[24:20];
    ebreak_d = inst_q == 32'h0010_0073;
    // Upper-immediate field width differs with XLEN because shamt grows to 6 bits on RV64
    if (XLEN == 64) begin
      sll_ok = inst_q[31:26] == 6'h00;
      sr_ok  = inst_q[31:26] == 6'h00 || inst_q[31:26] == 6'h10;
    end else begin
      sll_ok = inst_q[31:25] == 7'h00;
      sr_ok  = inst_q[31:25] == 7'h00 || inst_q[31:25] == 7'h20;
    end
    w_res    = '0;
    result_d = '0;
    legal_d  = 1'b0;
    case (opcode)
      7'h13: begin
        legal_d = 1'b1;
        case (funct3)
          3'b000:  result_d = rs1_val + imm_i;
          3'b010:  result_d = XLEN'($signed(rs1_val) < $signed(imm_i));
          3'b011:  result_d = XLEN'(rs1_val < imm_i);
          3'b100:  result_d = rs1_val ^ imm_i;
          3'b110:  result_d = rs1_val | imm_i;
          3'b111:  result_d = rs1_val & imm_i;
          3'b001: begin
            result_d = rs1_val << shamt;
            legal_d  = sll_ok;
          end
          default: begin
            result_d = inst_q[30] ? sra_x : (rs1_val >> shamt);
            legal_d  = sr_ok;
          end
        endcase
      end
      7'h1B: begin
        case (funct3)
          3'b000: begin
            w_res   = rs1_val[31:0] + imm_i[31:0];
            legal_d = XLEN == 64;
          end
          3'b001: begin
            w_res   = rs1_val[31:0] << inst_q[24:20];
            legal_d = XLEN == 64 && inst_q[31:25] == 7'h00;
          end
          3'b101: begin
            w_res   = inst_q[30] ? sra_w : (rs1_val[31:0] >> inst_q[24:20]);
            legal_d = XLEN == 64 && (inst_q[31:25] == 7'h00 || inst_q[31:25] == 7'h20);
          end
          default: legal_d = 1'b0;
        endcase
        result_d = XLEN'($signed(w_res));
      end
      7'h37: begin
        legal_d  = 1'b1;
        result_d = imm_u;
      end
      default: legal_d = 1'b0;
    endcase
    // LUI carries immediate bits in the rs1 field, so only register-sourcing ops check it
    legal_d = legal_d && !rd_oob && !(opcode != 7'h37 && rs1_oob);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      out_q     <= '0;
      rd_q      <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io_inst_valid) begin
            inst_q  <= io_inst;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (ebreak_d) begin
            halt_q  <= 1'b1;
            state_q <= HALT;
          end else if (!legal_d) begin
            halt_q    <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= HALT;
          end else begin
            out_q   <= result_d;
            rd_q    <= rd_idx[RW-1:0];
            state_q <= WB;
          end
        end
        WB: begin
          if (rd_q != '0) rf_q[rd_q] <= out_q;
          state_q <= IDLE;
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_inst_ready = state_q == IDLE;
  assign io_out_valid  = state_q == WB;
  assign io_out        = out_q;
  assign io_out_rd     = rd_q;
  assign io_halt       = halt_q;
  assign io_illegal    = illegal_q;
  assign io_dbg_rdata  = (io_dbg_raddr == '0) ? '0 : rf_q[io_dbg_raddr];

endmodule

// File: tb/tb_imm_alu_core.sv
// Bench for imm_alu_core: directed literal checks plus randomized instructions
// compared every cycle against a behavioural model of the core.
module tb_imm_alu_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_inst_valid = 1'b0;
  logic        io_inst_ready;
  logic [31:0] io_inst = '0;
  logic        io_out_valid;
  logic [63:0] io_out;
  logic [4:0]  io_out_rd;
  logic        io_halt;
  logic        io_illegal;
  logic [4:0]  io_dbg_raddr = '0;
  logic [63:0] io_dbg_rdata;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_inst = '0;
  logic        s_out_valid;
  logic [31:0] s_out;
  logic [4:0]  s_out_rd;
  logic        s_halt;
  logic        s_illegal;
  logic [4:0]  s_dbg_raddr = '0;
  logic [31:0] s_dbg_rdata;

  always #5 clock = ~clock;

  imm_alu_core #(.XLEN(64), .NREGS(32)) dut (
    .clock(clock), .reset(reset),
    .io_inst_valid(io_inst_valid), .io_inst_ready(io_inst_ready), .io_inst(io_inst),
    .io_out_valid(io_out_valid), .io_out(io_out), .io_out_rd(io_out_rd),
    .io_halt(io_halt), .io_illegal(io_illegal),
    .io_dbg_raddr(io_dbg_raddr), .io_dbg_rdata(io_dbg_rdata)
  );

  imm_alu_core #(.XLEN(32), .NREGS(32)) dut32 (
    .clock(clock), .reset(reset),
    .io_inst_valid(s_valid), .io_inst_ready(s_ready), .io_inst(s_inst),
    .io_out_valid(s_out_valid), .io_out(s_out), .io_out_rd(s_out_rd),
    .io_halt(s_halt), .io_illegal(s_illegal),
    .io_dbg_raddr(s_dbg_raddr), .io_dbg_rdata(s_dbg_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: kind 0 = writeback, 1 = ebreak, 2 = illegal
  function automatic void ref_exec(input logic [31:0] in, input logic [63:0] a,
                                   output int kind, output logic [63:0] r);
    logic [63:0] uimm;
    longint      simm;
    longint      sa;
    int          sw;
    logic [31:0] w;
    int unsigned sh;
    uimm = {{52{in[31]}}, in[31:20]};
    simm = uimm;
    sa   = a;
    sh   = in[25:20];
    kind = 0;
    r    = '0;
    w    = '0;
    case (in[6:0])
      7'h13: case (in[14:12])
        3'd0: r = a + uimm;
        3'd2: r = (sa < simm) ? 64'd1 : 64'd0;
        3'd3: r = (a < uimm) ? 64'd1 : 64'd0;
        3'd4: r = a ^ uimm;
        3'd6: r = a | uimm;
        3'd7: r = a & uimm;
        3'd1: if (in[31:26] != 6'h00) kind = 2; else r = a << sh;
        default: begin
          if (in[31:26] == 6'h00) r = a >> sh;
          else if (in[31:26] == 6'h10) r = sa >>> sh;
          else kind = 2;
        end
      endcase
      7'h1B: begin
        case (in[14:12])
          3'd0: w = a[31:0] + uimm[31:0];
          3'd1: if (in[31:25] != 7'h00) kind = 2; else w = a[31:0] << in[24:20];
          3'd5: begin
            sw = a[31:0];
            if (in[31:25] == 7'h00) w = a[31:0] >> in[24:20];
            else if (in[31:25] == 7'h20) w = sw >>> in[24:20];
            else kind = 2;
          end
          default: kind = 2;
        endcase
        if (kind == 0) r = {{32{w[31]}}, w};
      end
      7'h37: r = {{32{in[31]}}, in[31:12], 12'h000};
      default: kind = (in == 32'h0010_0073) ? 1 : 2;
    endcase
  endfunction

  logic [63:0] mreg [32];
  int          cyc = 0;
  bit          inflight = 0;
  bit          m_halted = 0;
  int          since = 0;
  int          m_kind = 0;
  logic [63:0] m_res = '0;
  logic [4:0]  m_rd = '0;
  logic [63:0] e_out = '0;
  logic [4:0]  e_rd = '0;
  bit          e_valid = 0;
  bit          e_ready = 1;
  bit          e_halt = 0;
  bit          e_ill = 0;
  bit          chk_en = 0;
  int          dbg_force = -1;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      inflight = 0; m_halted = 0;
      e_out = '0; e_rd = '0; e_valid = 0; e_ready = 1; e_halt = 0; e_ill = 0;
      chk_en = 1;
    end else if (inflight) begin
      since++;
      if (since == 2) begin
        if (m_kind == 0) begin
          e_valid = 1; e_out = m_res; e_rd = m_rd;
        end else begin
          e_halt = 1; e_ill = (m_kind == 2); m_halted = 1; inflight = 0;
        end
      end else begin
        e_valid = 0;
        if (m_rd != 5'd0) mreg[m_rd] = m_res;
        e_ready = 1;
        inflight = 0;
      end
    end else if (e_ready && io_inst_valid) begin
      ref_exec(io_inst, mreg[io_inst[19:15]], m_kind, m_res);
      m_rd = io_inst[11:7];
      inflight = 1; since = 1; e_ready = 0;
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("ready", io_inst_ready, e_ready);
      chk("out_valid", io_out_valid, e_valid);
      chk("out", io_out, e_out);
      chk("out_rd", io_out_rd, e_rd);
      chk("halt", io_halt, e_halt);
      chk("illegal", io_illegal, e_ill);
      chk("dbg_rdata", io_dbg_rdata, mreg[io_dbg_raddr]);
      io_dbg_raddr = (dbg_force >= 0) ? dbg_force[4:0] : 5'($urandom_range(0, 31));
    end
  end

  int hs_cyc = 0;
  int last_hs = 0;

  task automatic send(input logic [31:0] in, input bit hold);
    bit ok;
    ok = 0;
    @(negedge clock);
    io_inst = in;
    io_inst_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (io_inst_ready) begin ok = 1; break; end
      if (m_halted) break;
      @(negedge clock);
    end
    if (!m_halted) chk("handshake", ok, 1'b1);
    if (ok) begin last_hs = hs_cyc; hs_cyc = cyc; end
    @(negedge clock);
    if (!hold) io_inst_valid = 1'b0;
  endtask

  task automatic expect_wb(input string nm, input logic [63:0] ex, input logic [4:0] exrd);
    int n;
    n = 0;
    while (!io_out_valid && n < 10) begin @(negedge clock); n++; end
    chk({nm, "_latency"}, 64'(cyc - hs_cyc), 64'd2);
    chk({nm, "_out"}, io_out, ex);
    chk({nm, "_rd"}, io_out_rd, exrd);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    io_inst_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [31:0] d_inst [9] = '{32'h00508113, 32'h0000A193, 32'h0010B213, 32'h0F00C293,
                              32'h80000337, 32'h02035393, 32'h42035413, 32'h0003849B,
                              32'h0013849B};
  logic [63:0] d_exp  [9] = '{64'd4, 64'd1, 64'd0, 64'hFFFFFFFFFFFFFF0F,
                              64'hFFFFFFFF80000000, 64'h00000000FFFFFFFF,
                              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0};
  logic [4:0]  d_rd   [9] = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd9};

  initial begin
    int nv;
    logic [31:0] r;
    int pick;

    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst_ready", io_inst_ready, 1'b1);
    chk("rst_out", io_out, 64'd0);

    // RV32 build: plain addi, then the shamt[5]-set slli form is illegal
    s_inst = 32'hFFF00093; s_valid = 1'b1;
    @(negedge clock); s_valid = 1'b0;
    @(negedge clock);
    chk("x32_valid", s_out_valid, 1'b1);
    chk("x32_addi", s_out, 32'hFFFFFFFF);
    chk("x32_rd", s_out_rd, 5'd1);
    @(negedge clock);
    chk("x32_ready", s_ready, 1'b1);
    s_inst = 32'h04009093; s_valid = 1'b1;
    @(negedge clock); s_valid = 1'b0;
    @(negedge clock);
    chk("x32_halt", s_halt, 1'b1);
    chk("x32_illegal", s_illegal, 1'b1);

    dbg_force = 1;
    send(32'hFFF00093, 0);
    expect_wb("addi_m1", 64'hFFFFFFFFFFFFFFFF, 5'd1);
    @(negedge clock); #1;
    chk("dbg_x1", io_dbg_rdata, 64'hFFFFFFFFFFFFFFFF);
    chk("ready_c3", io_inst_ready, 1'b1);
    dbg_force = -1;

    for (int i = 0; i < 9; i++) begin
      send(d_inst[i], i >= 7);
      expect_wb($sformatf("dir%0d", i), d_exp[i], d_rd[i]);
      if (i == 8) begin
        io_inst_valid = 1'b0;
        chk("b2b_spacing", 64'(hs_cyc - last_hs), 64'd3);
      end
    end

    dbg_force = 0;
    send(32'h00500013, 0);
    expect_wb("addi_x0", 64'd5, 5'd0);
    @(negedge clock); #1;
    chk("dbg_x0", io_dbg_rdata, 64'd0);

    dbg_force = 1;
    send(32'h00700093, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    nv = 0;
    repeat (4) begin
      @(negedge clock);
      if (io_out_valid) nv++;
    end
    #1;
    chk("rst_exec_novalid", 64'(nv), 64'd0);
    chk("rst_exec_x1", io_dbg_rdata, 64'd0);
    dbg_force = -1;

    send(32'h00100073, 1);
    @(negedge clock);
    chk("ebreak_halt", io_halt, 1'b1);
    chk("ebreak_illegal", io_illegal, 1'b0);
    chk("ebreak_novalid", io_out_valid, 1'b0);
    repeat (10) begin
      @(negedge clock);
      chk("halt_ready", io_inst_ready, 1'b0);
    end
    do_reset();
    send(32'h00000000, 0);
    @(negedge clock);
    chk("zero_halt", io_halt, 1'b1);
    chk("zero_illegal", io_illegal, 1'b1);
    do_reset();

    for (int t = 0; t < 400; t++) begin
      if (m_halted) do_reset();
      r = $urandom;
      pick = $urandom_range(0, 9);
      if (pick < 4) r[6:0] = 7'h13;
      else if (pick < 6) r[6:0] = 7'h1B;
      else if (pick < 8) r[6:0] = 7'h37;
      else if (pick == 8) r[6:0] = 7'h13;
      if ((r[6:0] == 7'h13 || r[6:0] == 7'h1B) && $urandom_range(0, 3) != 0) begin
        r[31:26] = ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h00;
        if (r[6:0] == 7'h1B) r[25] = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) r = 32'h0010_0073;
      send(r, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      if ($urandom_range(0, 29) == 0) do_reset();
    end
    io_inst_valid = 1'b0;
    repeat (6) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
